// File: rtl/fp_issue_ctrl.sv
// Single-issue FP instruction controller: decodes one R/I-type FP instruction,
// holds it for a per-operation latency, then raises a one-cycle writeback strobe.
module fp_issue_ctrl #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 8,
  parameter int LAT_SQRT = 12
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        flush,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [15:0] immediate,
  output logic        fp_alu_src,
  output logic        fp_reg_dst,
  output logic [2:0]  fp_alu_ctrl,
  output logic        fp_wb_en,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q;
  logic        accept;

  logic        dec_legal;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  logic [15:0] dec_imm;
  logic        dec_src, dec_dst;
  logic [2:0]  dec_ctrl;
  logic [3:0]  dec_lat;

  always_comb begin
    dec_legal = 1'b0;
    dec_rs    = instr[25:21];
    dec_rt    = instr[20:16];
    dec_rd    = instr[15:11];
    dec_imm   = 16'd0;
    dec_src   = 1'b0;
    dec_dst   = 1'b1;
    dec_ctrl  = 3'b000;
    dec_lat   = 4'(LAT_ADD);
    case (instr[31:26])
      6'b010001: begin
        dec_legal = 1'b1;
        case (instr[5:0])
          6'h00: dec_ctrl = 3'b000;
          6'h01: dec_ctrl = 3'b001;
          6'h02: begin dec_ctrl = 3'b010; dec_lat = 4'(LAT_MUL);  end
          6'h03: begin dec_ctrl = 3'b011; dec_lat = 4'(LAT_DIV);  end
          6'h04: begin dec_ctrl = 3'b100; dec_lat = 4'(LAT_SQRT); end
          6'h20: dec_ctrl = 3'b101;
          6'h24: dec_ctrl = 3'b110;
          default: dec_legal = 1'b0;
        endcase
      end
      6'b111000, 6'b111001: begin
        dec_legal = 1'b1;
        dec_rd    = 5'd0;
        dec_imm   = instr[15:0];
        dec_src   = 1'b1;
        dec_dst   = 1'b0;
        if (instr[26]) begin
          dec_ctrl = 3'b010;
          dec_lat  = 4'(LAT_MUL);
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // flush in IDLE suppresses acceptance for that cycle
  assign accept      = instr_valid & ready_q & ~flush;
  assign instr_ready = ready_q;

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (dec_legal) begin
          state_d = S_EXEC;
          cnt_d   = dec_lat - 4'd1;
        end else begin
          state_d = S_ERR;
        end
      end
      S_EXEC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fp_wb_en = (state_q == S_WB);
    illegal  = (state_q == S_ERR);
    busy     = (state_q == S_EXEC) || (state_q == S_WB);
  end

  // Decoded fields only change on a legal accept; illegal words leave them intact
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      Rs          <= 5'd0;
      Rt          <= 5'd0;
      Rd          <= 5'd0;
      immediate   <= 16'd0;
      fp_alu_src  <= 1'b0;
      fp_reg_dst  <= 1'b0;
      fp_alu_ctrl <= 3'b000;
    end else if (accept && dec_legal) begin
      Rs          <= dec_rs;
      Rt          <= dec_rt;
      Rd          <= dec_rd;
      immediate   <= dec_imm;
      fp_alu_src  <= dec_src;
      fp_reg_dst  <= dec_dst;
      fp_alu_ctrl <= dec_ctrl;
    end
  end

endmodule
